// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// Latency: pure wiring, none of its own.
// Backpressure: none here; mem_ready is the only stall input and the controller samples it.
interface multicycle_control_if #(
    parameter int ALU_OP_W = 6
);
    logic [5:0]          op;
    logic [5:0]          funct;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                ir_write;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0]          state;
    logic                illegal;
    logic                timeout;

    // Controller side: reads the instruction fields and flags, drives the strobes.
    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
               reg_dst, mem_to_reg, alu_op, state, illegal, timeout
    );

    // Datapath/memory side.
    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
               reg_dst, mem_to_reg, alu_op, state, illegal, timeout
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencer with illegal-op and memory-timeout halts.
// Latency: R/ADDI 4, LW 5, SW 4, BEQ 3, J 2 cycles when mem_ready is immediate; outputs are combinational from state.
// Backpressure: FETCH and MEM stall while mem_ready is low, up to MEM_TIMEOUT cycles, then HALT.
module multicycle_control #(
    parameter int ALU_OP_W    = 6,
    parameter int EXT_RTYPE   = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Class codes double as the EXEC alu_op value; J never reaches EXEC.
    typedef enum logic [3:0] {
        C_ADD  = 4'd0,
        C_ADDI = 4'd1,
        C_LW   = 4'd2,
        C_SW   = 4'd3,
        C_BEQ  = 4'd4,
        C_SUB  = 4'd5,
        C_AND  = 4'd6,
        C_OR   = 4'd7,
        C_SLT  = 4'd8,
        C_J    = 4'd9
    } cls_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    state_t           state_q, state_d;
    cls_t             cls_q, dec_cls;
    logic             dec_ok;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             live_q;
    logic             illegal_q, timeout_q;
    logic             set_ill, set_to;
    logic             wait_expired;
    logic             cls_is_r;

    assign cnt_inc      = cnt_q + 1'b1;
    assign wait_expired = !bus.mem_ready && (cnt_inc == CNT_W'(MEM_TIMEOUT));
    assign cls_is_r     = (cls_q == C_ADD) || (cls_q == C_SUB) || (cls_q == C_AND) ||
                          (cls_q == C_OR)  || (cls_q == C_SLT);

    assign bus.state   = state_q;
    assign bus.illegal = illegal_q;
    assign bus.timeout = timeout_q;

    // Classify the instruction currently presented on op/funct.
    always_comb begin
        dec_cls = C_ADD;
        dec_ok  = 1'b1;
        case (bus.op)
            OP_R: begin
                case (bus.funct)
                    F_ADD:   dec_cls = C_ADD;
                    F_SUB:   dec_cls = C_SUB;
                    F_AND:   dec_cls = C_AND;
                    F_OR:    dec_cls = C_OR;
                    F_SLT:   dec_cls = C_SLT;
                    default: dec_ok  = 1'b0;
                endcase
                if (EXT_RTYPE == 0 && bus.funct != F_ADD) dec_ok = 1'b0;
            end
            OP_J:    dec_cls = C_J;
            OP_BEQ:  dec_cls = C_BEQ;
            OP_ADDI: dec_cls = C_ADDI;
            OP_LW:   dec_cls = C_LW;
            OP_SW:   dec_cls = C_SW;
            default: dec_ok  = 1'b0;
        endcase
    end

    // Next state, wait counter and control strobes; nothing moves until the first edge after reset.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        set_ill        = 1'b0;
        set_to         = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'd0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_op     = '0;
        if (live_q) begin
            case (state_q)
                FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = DECODE;
                    end else if (wait_expired) begin
                        set_to  = 1'b1;
                        state_d = HALT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                DECODE: begin
                    if (!dec_ok) begin
                        set_ill = 1'b1;
                        state_d = HALT;
                    end else if (dec_cls == C_J) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 2'd2;
                        state_d      = FETCH;
                    end else begin
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    bus.alu_op = ALU_OP_W'(cls_q);
                    case (cls_q)
                        C_BEQ: begin
                            bus.pc_write = bus.zero;
                            bus.pc_src   = 2'd1;
                            state_d      = FETCH;
                        end
                        C_LW, C_SW: state_d = MEM;
                        default:    state_d = WB;
                    endcase
                end
                MEM: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = (cls_q == C_SW);
                    if (bus.mem_ready) begin
                        state_d = (cls_q == C_LW) ? WB : FETCH;
                    end else if (wait_expired) begin
                        set_to  = 1'b1;
                        state_d = HALT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = cls_is_r;
                    bus.mem_to_reg = (cls_q == C_LW);
                    state_d        = FETCH;
                end
                HALT:    state_d = HALT;
                default: state_d = HALT;
            endcase
            // Any state change restarts the wait count, so FETCH and MEM always begin at zero.
            if (state_d != state_q) cnt_d = '0;
        end
    end

    // State, wait counter, latched instruction class and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q    <= 1'b0;
            state_q   <= FETCH;
            cnt_q     <= '0;
            cls_q     <= C_ADD;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (live_q && state_q == DECODE) cls_q <= dec_cls;
            if (set_ill) illegal_q <= 1'b1;
            if (set_to)  timeout_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (extended R-type/timeout 16, ADD-only/timeout 4) share stimulus.
// Each is compared every cycle against an instruction-plan reference model, plus table vectors and corner sequences.
// Inputs change just after the falling edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_multicycle_control;
    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    multicycle_control_if #(.ALU_OP_W(6)) ia();
    multicycle_control_if #(.ALU_OP_W(6)) ib();

    assign ia.op = op;  assign ia.funct = funct;  assign ia.zero = zero;  assign ia.mem_ready = mem_ready;
    assign ib.op = op;  assign ib.funct = funct;  assign ib.zero = zero;  assign ib.mem_ready = mem_ready;

    multicycle_control #(.ALU_OP_W(6), .EXT_RTYPE(1), .MEM_TIMEOUT(16)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    multicycle_control #(.ALU_OP_W(6), .EXT_RTYPE(0), .MEM_TIMEOUT(4))  dut_b (.clk(clk), .rst(rst), .bus(ib));

    logic [19:0] act_a, act_b;
    assign act_a = {ia.state, ia.mem_req, ia.mem_we, ia.ir_write, ia.pc_write, ia.pc_src,
                    ia.reg_write, ia.reg_dst, ia.mem_to_reg, ia.alu_op, ia.illegal, ia.timeout};
    assign act_b = {ib.state, ib.mem_req, ib.mem_we, ib.ir_write, ib.pc_write, ib.pc_src,
                    ib.reg_write, ib.reg_dst, ib.mem_to_reg, ib.alu_op, ib.illegal, ib.timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phases 0..5 are FETCH..HALT; an instruction is a plan of phases after DECODE.
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;
    int m_ph[2], m_wait[2], m_kind[2], m_len[2], m_pos[2];
    int m_plan[2][3];
    bit m_live[2], m_ill[2], m_to[2];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic int lim(input int d);
        return (d == 0) ? 16 : 4;
    endfunction

    // Instruction kind = its ALU code, J = 9, unsupported = -1.
    function automatic int kind_of(input int d, input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00: begin
                if (f == 6'h20) return 0;
                if (d != 0) return -1;
                case (f)
                    6'h22:   return 5;
                    6'h24:   return 6;
                    6'h25:   return 7;
                    6'h2A:   return 8;
                    default: return -1;
                endcase
            end
            6'h02:   return 9;
            6'h04:   return 4;
            6'h08:   return 1;
            6'h23:   return 2;
            6'h2B:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_live[d] = 0; m_ph[d] = P_F; m_wait[d] = 0; m_kind[d] = 0;
            m_ill[d] = 0; m_to[d] = 0; m_pos[d] = 0; m_len[d] = 0;
        end
    endtask

    function automatic logic [19:0] model_out(input int d);
        logic mr, mw, iw, pw, rw, rd, mtr;
        logic [1:0] ps;
        logic [5:0] alu;
        int k;
        {mr, mw, iw, pw, rw, rd, mtr} = '0;
        ps = 2'd0;
        alu = 6'd0;
        k = m_kind[d];
        if (m_live[d]) begin
            case (m_ph[d])
                P_F: begin mr = 1; if (mem_ready) begin iw = 1; pw = 1; end end
                P_D: if (kind_of(d, op, funct) == 9) begin pw = 1; ps = 2'd2; end
                P_E: begin alu = 6'(k); if (k == 4) begin pw = zero; ps = 2'd1; end end
                P_M: begin mr = 1; mw = (k == 3); end
                P_W: begin rw = 1; rd = (k == 0) || (k >= 5 && k <= 8); mtr = (k == 2); end
                default: ;
            endcase
        end
        return {3'(m_ph[d]), mr, mw, iw, pw, ps, rw, rd, mtr, alu, m_ill[d], m_to[d]};
    endfunction

    task automatic next_phase(input int d);
        if (m_ph[d] == P_F) m_ph[d] = P_D;
        else begin
            m_pos[d]++;
            m_ph[d] = (m_pos[d] < m_len[d]) ? m_plan[d][m_pos[d]] : P_F;
        end
        m_wait[d] = 0;
    endtask

    task automatic model_adv(input int d);
        int k;
        if (!m_live[d]) begin m_live[d] = 1; return; end
        case (m_ph[d])
            P_F, P_M: begin
                if (mem_ready) next_phase(d);
                else begin
                    m_wait[d]++;
                    if (m_wait[d] == lim(d)) begin m_to[d] = 1; m_ph[d] = P_H; end
                end
            end
            P_D: begin
                k = kind_of(d, op, funct);
                if (k < 0) begin m_ill[d] = 1; m_ph[d] = P_H; end
                else begin
                    m_kind[d] = k;
                    case (k)
                        2: begin m_plan[d][0] = P_E; m_plan[d][1] = P_M; m_plan[d][2] = P_W; m_len[d] = 3; end
                        3: begin m_plan[d][0] = P_E; m_plan[d][1] = P_M; m_len[d] = 2; end
                        4: begin m_plan[d][0] = P_E; m_len[d] = 1; end
                        9: m_len[d] = 0;
                        default: begin m_plan[d][0] = P_E; m_plan[d][1] = P_W; m_len[d] = 2; end
                    endcase
                    m_pos[d] = -1;
                    next_phase(d);
                end
            end
            P_E, P_W: next_phase(d);
            default: ;
        endcase
    endtask

    // One clock: drive inputs, compare both instances with the model, then advance the model past the edge.
    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
        @(negedge clk);
        op = o; funct = f; zero = z; mem_ready = r;
        #1;
        chk("cycle_a", int'(act_a), int'(model_out(0)));
        chk("cycle_b", int'(act_b), int'(model_out(1)));
        model_adv(0);
        model_adv(1);
    endtask

    // Asynchronous reset pulse in mid-cycle; outputs must drop to zero at once.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("reset_a", int'(act_a), 0);
        chk("reset_b", int'(act_b), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          len;
        logic [19:0] path;   // one state per nibble, first state in the top nibble
        int          alu;
    } vec_t;

    vec_t tbl[11];
    logic [5:0] lop [6];
    logic [5:0] lfn [5];
    logic [8:0] rdy_seq;
    int na, nb;

    initial begin
        tbl[0]  = '{6'h00, 6'h20, 1'b0, 4, 20'h01240, 0};
        tbl[1]  = '{6'h00, 6'h22, 1'b0, 4, 20'h01240, 5};
        tbl[2]  = '{6'h00, 6'h24, 1'b0, 4, 20'h01240, 6};
        tbl[3]  = '{6'h00, 6'h25, 1'b0, 4, 20'h01240, 7};
        tbl[4]  = '{6'h00, 6'h2A, 1'b0, 4, 20'h01240, 8};
        tbl[5]  = '{6'h08, 6'h00, 1'b0, 4, 20'h01240, 1};
        tbl[6]  = '{6'h23, 6'h00, 1'b0, 5, 20'h01234, 2};
        tbl[7]  = '{6'h2B, 6'h00, 1'b0, 4, 20'h01230, 3};
        tbl[8]  = '{6'h04, 6'h00, 1'b1, 3, 20'h01200, 4};
        tbl[9]  = '{6'h04, 6'h00, 1'b0, 3, 20'h01200, 4};
        tbl[10] = '{6'h02, 6'h00, 1'b0, 2, 20'h01000, 0};
        lop = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
        lfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        rst = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        model_reset();
        do_reset();

        // Table vectors on the extended instance, memory always ready.
        step(6'h00, 6'h20, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < tbl[i].len; c++) begin
                step(tbl[i].op, tbl[i].funct, tbl[i].zero, 1'b1);
                chk($sformatf("path%0d_%0d", i, c), int'(ia.state), int'(tbl[i].path[4*(4-c) +: 4]));
                if (c == 2 && tbl[i].len > 2) chk($sformatf("alu%0d", i), int'(ia.alu_op), tbl[i].alu);
            end
        end

        // LW with three wait cycles in MEM: MEM lasts four cycles on both instances.
        do_reset();
        step(6'h23, 6'h00, 1'b0, 1'b1);
        rdy_seq = 9'b111000111;
        na = 0; nb = 0;
        for (int c = 0; c < 9; c++) begin
            step(6'h23, 6'h00, 1'b0, rdy_seq[c]);
            if (ia.state == 3'd3) na++;
            if (ib.state == 3'd3) nb++;
            if (c == 7) chk("lw_wb_mem_to_reg", int'(ia.mem_to_reg & ia.reg_write), 1);
        end
        chk("lw_mem_cycles_a", na, 4);
        chk("lw_mem_cycles_b", nb, 4);

        // FETCH wait reaching the limit of the short-timeout instance.
        do_reset();
        step(6'h00, 6'h20, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) step(6'h00, 6'h20, 1'b0, 1'b0);
        step(6'h00, 6'h20, 1'b0, 1'b1);
        chk("to_flag_b", int'(ib.timeout), 1);
        chk("to_state_b", int'(ib.state), 5);
        chk("to_flag_a", int'(ia.timeout), 0);

        // Ready arriving on the last allowed wait cycle completes normally.
        do_reset();
        step(6'h00, 6'h20, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) step(6'h00, 6'h20, 1'b0, 1'b0);
        step(6'h00, 6'h20, 1'b0, 1'b1);
        step(6'h00, 6'h20, 1'b0, 1'b1);
        chk("ready_wins_b", int'(ib.state), 1);
        chk("ready_wins_to_b", int'(ib.timeout), 0);

        // SUB is illegal only on the ADD-only instance; 0x3F is illegal on both.
        do_reset();
        step(6'h00, 6'h22, 1'b0, 1'b1);
        step(6'h00, 6'h22, 1'b0, 1'b1);
        step(6'h00, 6'h22, 1'b0, 1'b1);
        step(6'h00, 6'h22, 1'b0, 1'b1);
        chk("ill_flag_b", int'(ib.illegal), 1);
        chk("ill_state_b", int'(ib.state), 5);
        chk("sub_exec_a", int'(ia.state), 2);
        step(6'h00, 6'h22, 1'b0, 1'b1);
        step(6'h3F, 6'h00, 1'b0, 1'b1);
        step(6'h3F, 6'h00, 1'b0, 1'b1);
        step(6'h3F, 6'h00, 1'b0, 1'b1);
        chk("ill_flag_a", int'(ia.illegal), 1);
        chk("ill_state_a", int'(ia.state), 5);
        do_reset();
        step(6'h00, 6'h20, 1'b0, 1'b1);
        chk("ill_clear_a", int'(ia.illegal), 0);
        chk("ill_clear_b", int'(ib.illegal), 0);
        chk("ill_clear_state_b", int'(ib.state), 0);

        // SW interrupted by reset while waiting in MEM.
        do_reset();
        step(6'h2B, 6'h00, 1'b0, 1'b1);
        step(6'h2B, 6'h00, 1'b0, 1'b1);
        step(6'h2B, 6'h00, 1'b0, 1'b1);
        step(6'h2B, 6'h00, 1'b0, 1'b1);
        step(6'h2B, 6'h00, 1'b0, 1'b0);
        chk("sw_in_mem_a", int'(ia.state), 3);
        chk("sw_we_a", int'(ia.mem_we), 1);
        do_reset();
        step(6'h2B, 6'h00, 1'b0, 1'b1);
        chk("sw_abort_state_a", int'(ia.state), 0);
        chk("sw_abort_req_a", int'(ia.mem_req), 0);

        // Random instruction mix with stalls and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) do_reset();
            else step(($urandom_range(0, 19) < 18) ? lop[$urandom_range(0, 5)] : 6'($urandom),
                      ($urandom_range(0, 9) < 9) ? lfn[$urandom_range(0, 4)] : 6'($urandom),
                      1'($urandom), $urandom_range(0, 9) < 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALU_OP_W, default 6: alu_op width; must be >= 4.
REQ-002 Parameter EXT_RTYPE, default 1: 1 = SUB/AND/OR/SLT legal; 0 = only ADD legal among R-type.
REQ-003 Parameter MEM_TIMEOUT, default 16: maximum wait cycles for mem_ready; must be >= 1.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 op  in  6  instruction opcode from external IR.
REQ-007 funct  in  6  R-type function field from external IR.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 mem_ready  in  1  memory completes the current request this cycle.
REQ-010 mem_req  out  1  memory access request.
REQ-011 mem_we  out  1  store qualifier for mem_req.
REQ-012 ir_write  out  1  load IR from memory data.
REQ-013 pc_write  out  1  update PC.
REQ-014 pc_src  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target.
REQ-015 reg_write  out  1  register file write enable.
REQ-016 reg_dst  out  1  destination register: 1 = rd, 0 = rt.
REQ-017 mem_to_reg  out  1  writeback data: 1 = memory, 0 = ALU.
REQ-018 alu_op  out  ALU_OP_W  ALU operation code.
REQ-019 state  out  3  current state, for debug.
REQ-020 illegal  out  1  sticky flag: unsupported instruction decoded.
REQ-021 timeout  out  1  sticky flag: memory wait exceeded MEM_TIMEOUT.

Function
REQ-022 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to HALT on the next edge.
REQ-023 Every output not explicitly asserted in the current state SHALL be 0.
REQ-024 Opcodes: R=0x00, J=0x02, BEQ=0x04, ADDI=0x08, LW=0x23, SW=0x2B.
REQ-025 Funct codes: ADD=0x20, SUB=0x22, AND=0x24, OR=0x25, SLT=0x2A.
REQ-026 FETCH: mem_req=1, mem_we=0; on mem_ready=1, assert ir_write=1 and pc_write=1 (pc_src=0) that cycle, then go to DECODE.
REQ-027 DECODE: latch the instruction class from op/funct; later states SHALL use only the latched class.
REQ-028 DECODE, illegal op or R-type funct (subject to EXT_RTYPE): set illegal, go to HALT.
REQ-029 DECODE, J: pc_write=1, pc_src=2, go to FETCH.
REQ-030 DECODE, all other legal instructions: go to EXEC.
REQ-031 EXEC alu_op values (zero-extended): ADD=0, ADDI=1, LW=2, SW=3, BEQ=4, SUB=5, AND=6, OR=7, SLT=8.
REQ-032 EXEC, BEQ: pc_write=zero (combinational, same cycle), pc_src=1, go to FETCH.
REQ-033 EXEC, LW/SW: go to MEM; R-type/ADDI: go to WB.
REQ-034 MEM: mem_req=1, mem_we=1 for SW only; on mem_ready, SW goes to FETCH and LW goes to WB.
REQ-035 WB: reg_write=1; reg_dst=1 for R-type; mem_to_reg=1 for LW; go to FETCH.
REQ-036 Wait counter: clears on entry to FETCH/MEM; increments each cycle mem_ready=0.
REQ-037 If counter reaches MEM_TIMEOUT with mem_ready=0: set timeout, go to HALT, no ir_write/pc_write.
REQ-038 mem_ready=1 on the cycle the counter reaches MEM_TIMEOUT SHALL complete normally (ready wins).
REQ-039 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-040 HALT: all control outputs 0; remain in HALT until reset; illegal/timeout hold.
REQ-041 Latency, with mem_ready=1 immediately: R/ADDI 4 cycles, LW 5, SW 4, BEQ 3, J 2.

Reset
REQ-042 rst=0 SHALL immediately and asynchronously force: state=FETCH, counter=0, latched class=0, illegal=0, timeout=0, and all outputs 0.
REQ-043 While rst=0, mem_req SHALL be 0; FETCH outputs start on the first clk edge after rst rises.
REQ-044 Reset during MEM or a wait SHALL abort the access with no write strobes.

Verification
REQ-045 ADD (op 0x00, funct 0x20), mem_ready=1 -> states 0,1,2,4; alu_op=0; reg_write=1 and reg_dst=1 in WB.
REQ-046 LW, mem_ready low 3 cycles in MEM -> MEM held 4 cycles; mem_we=0; WB has mem_to_reg=1, reg_write=1.
REQ-047 BEQ with zero=1, then zero=0 -> pc_write=1, pc_src=1 in EXEC for the first; pc_write=0 for the second; both return to FETCH.
REQ-048 EXT_RTYPE=0 with funct 0x22, and op 0x3F -> illegal=1, state=5, then rst -> illegal=0, state=0.
REQ-049 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> timeout=1 after 4 cycles, no ir_write; separately, mem_ready=1 on the 4th cycle -> normal DECODE.
REQ-050 SW with rst pulsed low mid-MEM -> outputs 0 asynchronously; state=FETCH after release.
